// File: rtl/phy_tx_lanes.sv
// phy_tx_lanes: round-robin arbitrates NUM_IN byte channels and stripes words MSB-first across NUM_LANES serial lanes
// clk_8f/reset: bit clock and synchronous active-high reset
// data_in/valid_in/ready_out: per-channel word handshake, channel i at [i*WIDTH +: WIDTH]
// tx_out/lane_valid/frame_start: registered serial bits, per-frame lane data flag, MSB-of-frame marker
module phy_tx_lanes #(
    parameter int WIDTH = 8,
    parameter int NUM_IN = 2,
    parameter int NUM_LANES = 2,
    parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
    input  logic                    clk_8f,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [NUM_IN-1:0]       valid_in,
    output logic [NUM_IN-1:0]       ready_out,
    output logic [NUM_LANES-1:0]    tx_out,
    output logic [NUM_LANES-1:0]    lane_valid,
    output logic                    frame_start
);
    localparam int CW = $clog2(WIDTH);
    localparam int FW = $clog2(NUM_LANES + 1);
    localparam int RW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;

    logic [CW-1:0]    cnt;
    logic [FW-1:0]    fill;
    logic [RW-1:0]    rr, gnt, idx;
    logic             gnt_any, load, acc;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] stage [NUM_LANES];
    logic [WIDTH-1:0] sh [NUM_LANES];

    // search downward so the channel closest to rr is the last (winning) assignment
    always_comb begin
        gnt = '0;
        gnt_any = 1'b0;
        idx = '0;
        for (int j = NUM_IN - 1; j >= 0; j--) begin
            idx = RW'((int'(rr) + j) % NUM_IN);
            if (valid_in[idx]) begin
                gnt_any = 1'b1;
                gnt = idx;
            end
        end
    end

    // the load cycle frees the whole staging buffer, so it always has room
    always_comb begin
        load = cnt == CW'(WIDTH - 1);
        acc = gnt_any && (fill < FW'(NUM_LANES) || load);
        ready_out = acc ? NUM_IN'(1) << gnt : '0;
        word = data_in[int'(gnt) * WIDTH +: WIDTH];
        tx_out = '0;
        for (int k = 0; k < NUM_LANES; k++) tx_out[k] = sh[k][WIDTH-1];
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            cnt <= '0;
            fill <= '0;
            rr <= '0;
            frame_start <= 1'b0;
            lane_valid <= '0;
            for (int k = 0; k < NUM_LANES; k++) sh[k] <= '0;
        end else begin
            cnt <= load ? '0 : cnt + 1'b1;
            frame_start <= load;
            if (acc) rr <= (gnt == RW'(NUM_IN - 1)) ? '0 : gnt + 1'b1;
            fill <= load ? FW'(acc) : fill + FW'(acc);
            for (int k = 0; k < NUM_LANES; k++) begin
                sh[k] <= load ? (FW'(k) < fill ? stage[k] : IDLE_SYM) : {sh[k][WIDTH-2:0], 1'b0};
                if (load) lane_valid[k] <= FW'(k) < fill;
                // a load-cycle accept opens the next buffer at lane 0
                if (acc && (load ? k == 0 : FW'(k) == fill)) stage[k] <= word;
            end
        end
    end
endmodule

// File: tb/tb_phy_tx_lanes.sv
// tb_phy_tx_lanes: table vectors plus scoreboard of accepted words against reconstructed lane frames
module tb_phy_tx_lanes;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0, rst = 1'b1;
    logic [2:0] vin = '0;
    logic [9:0] din [3] = '{default: '0};
    logic       rst_a, rst_b, fs_a, fs_b, fs;
    logic [15:0] data_a;
    logic [29:0] data_b;
    logic [1:0] valid_a, ready_a, tx_a, lv_a;
    logic [2:0] valid_b, ready_b, rdy;
    logic [3:0] tx_b, lv_b, tx, lv;

    assign rst_a = sel ? 1'b1 : rst;
    assign rst_b = sel ? rst : 1'b1;
    assign data_a = {din[1][7:0], din[0][7:0]};
    assign data_b = {din[2], din[1], din[0]};
    assign valid_a = sel ? 2'b00 : vin[1:0];
    assign valid_b = sel ? vin : 3'b000;
    assign rdy = sel ? ready_b : {1'b0, ready_a};
    assign tx = sel ? tx_b : {2'b00, tx_a};
    assign lv = sel ? lv_b : {2'b00, lv_a};
    assign fs = sel ? fs_b : fs_a;

    phy_tx_lanes u_a (
        .clk_8f(clk), .reset(rst_a), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .tx_out(tx_a), .lane_valid(lv_a), .frame_start(fs_a)
    );

    phy_tx_lanes #(.WIDTH(10), .NUM_IN(3), .NUM_LANES(4), .IDLE_SYM(10'h17C)) u_b (
        .clk_8f(clk), .reset(rst_b), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .tx_out(tx_b), .lane_valid(lv_b), .frame_start(fs_b)
    );

    typedef struct {
        logic [2:0] v;
        logic [9:0] d0;
        logic [9:0] d1;
        logic [2:0] rdy;
    } vec_t;
    vec_t tbl [16];

    int W = 8, NI = 2, NL = 2;
    logic [9:0] idle = 10'h0BC, mask = 10'h0FF;
    int m_cnt = 0, m_fill = 0, m_rr = 0;
    logic fs_exp = 1'b0;
    bit started = 0, cap = 0;
    int bi = 0, cur_n = 0;
    logic [9:0] rx [4];
    logic [9:0] exp_q [$];
    int frm_q [$];
    logic [2:0] rdy_s;
    int nvec = 0, nfail = 0, naccept = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon();
        logic [9:0] w;
        chk("frame_start", fs, fs_exp);
        if (fs_exp) begin
            started = 1;
            cap = 1;
            bi = 0;
            cur_n = frm_q.size() > 0 ? frm_q.pop_front() : 0;
            for (int k = 0; k < 4; k++) rx[k] = '0;
        end
        if (!started) begin
            chk("tx_out before first frame", tx, 0);
            chk("lane_valid before first frame", lv, 0);
        end else if (cap) begin
            for (int k = 0; k < NL; k++) rx[k] = {rx[k][8:0], tx[k]};
            bi++;
            if (bi == W) begin
                cap = 0;
                for (int k = 0; k < NL; k++) begin
                    if (k < cur_n) begin
                        w = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                        chk($sformatf("lane%0d data", k), rx[k], w);
                    end else begin
                        chk($sformatf("lane%0d idle", k), rx[k], idle);
                    end
                    chk($sformatf("lane%0d lane_valid", k), lv[k], k < cur_n);
                end
            end
        end
    endtask

    task automatic cyc();
        logic [2:0] er;
        int g, t;
        bit ld, acc;
        @(negedge clk);
        rdy_s = rdy;
        er = '0;
        if (rst) begin
            m_cnt = 0;
            m_fill = 0;
            m_rr = 0;
            fs_exp = 1'b0;
            started = 0;
            cap = 0;
            exp_q.delete();
            frm_q.delete();
        end else begin
            ld = m_cnt == W - 1;
            g = -1;
            for (int j = 0; j < NI; j++) begin
                t = (m_rr + j) % NI;
                if (g < 0 && vin[t]) g = t;
            end
            acc = g >= 0 && (m_fill < NL || ld);
            if (acc) begin
                er[g] = 1'b1;
                exp_q.push_back(din[g] & mask);
                m_rr = (g + 1) % NI;
                naccept++;
            end
            if (ld) begin
                frm_q.push_back(m_fill);
                m_fill = acc;
            end else begin
                m_fill += acc;
            end
            fs_exp = ld;
            m_cnt = ld ? 0 : m_cnt + 1;
            chk("ready_out", rdy, er);
        end
        @(posedge clk);
        #1;
        mon();
    endtask

    initial begin
        int first, n0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].v = 3'b011;
            tbl[i].d0 = i == 0 ? 10'h11 : i < 8 ? 10'h22 : 10'h33;
            tbl[i].d1 = i < 2 ? 10'h99 : i < 9 ? 10'h88 : 10'h77;
            tbl[i].rdy = (i == 0 || i == 7 || i == 15) ? 3'b001 : (i == 1 || i == 8) ? 3'b010 : 3'b000;
        end

        rst = 1'b1;
        repeat (5) cyc();
        rst = 1'b0;
        repeat (24) cyc();

        while (m_cnt != 2) cyc();
        vin = 3'b001;
        din[0] = 10'hA5;
        cyc();
        chk("single word ready", rdy_s, 3'b001);
        vin = '0;
        repeat (16) cyc();

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vin = tbl[i].v;
            din[0] = tbl[i].d0;
            din[1] = tbl[i].d1;
            cyc();
            chk($sformatf("table row %0d ready", i), rdy_s, tbl[i].rdy);
        end
        vin = '0;
        repeat (16) cyc();

        while (m_cnt != 0) cyc();
        vin = 3'b011;
        din[0] = 10'h51;
        din[1] = 10'h62;
        cyc();
        cyc();
        vin = '0;
        while (m_cnt != 7) cyc();
        vin = 3'b001;
        din[0] = 10'h3C;
        cyc();
        chk("load cycle accept ready", rdy_s, 3'b001);
        vin = '0;
        repeat (20) cyc();

        while (m_cnt != 1) cyc();
        vin = 3'b001;
        din[0] = 10'h77;
        cyc();
        vin = '0;
        while (m_cnt != 5) cyc();
        rst = 1'b1;
        cyc();
        chk("outputs after mid-frame reset", {tx, lv, fs}, 0);
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (fs && first == 0) first = i;
        end
        chk("first frame_start after reset", first, 8);
        repeat (16) cyc();

        rst = 1'b1;
        sel = 1'b1;
        W = 10;
        NI = 3;
        NL = 4;
        idle = 10'h17C;
        mask = 10'h3FF;
        cyc();
        cyc();
        rst = 1'b0;
        n0 = naccept;
        repeat (300) begin
            vin = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) din[i] = 10'($urandom);
            cyc();
        end
        vin = '0;
        repeat (30) cyc();
        chk("sweep words accepted", naccept - n0 > 40, 1);
        chk("sweep leftover words", exp_q.size(), 0);
        chk("sweep leftover frames", frm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
